// File: rtl/mdu_pkg.sv
// Shared op codes and helpers for the execute-stage multiply/divide unit.
package mdu_pkg;

   localparam int MDU_CNT_W = 4;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;
   localparam logic [3:0] MDU_MADD  = 4'd9;
   localparam logic [3:0] MDU_MADDU = 4'd10;
   localparam logic [3:0] MDU_MSUB  = 4'd11;
   localparam logic [3:0] MDU_MSUBU = 4'd12;

   // Ops that occupy the unit for multiple cycles and write HI/LO on completion.
   function automatic logic mdu_is_long(input logic [3:0] op);
      return ((op >= MDU_MULT) && (op <= MDU_DIVU)) ||
             ((op >= MDU_MADD) && (op <= MDU_MSUBU));
   endfunction

   function automatic logic mdu_is_div(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational 64-bit {HI,LO} result for mul/div (and madd/msub when MDU_MADD_EN is defined).
// Divide by zero returns the incoming {HI,LO}, so committing it leaves the registers unchanged.
module e_mdu_core
   import mdu_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [63:0] res_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] acc;
   logic        div_s;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] den;
   logic [31:0] q_u;
   logic [31:0] r_u;
   logic [31:0] quo;
   logic [31:0] rem;

   assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
   assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};
   assign acc    = {hi_i, lo_i};

   // One unsigned divider serves both div and divu; signed operands are handled
   // as magnitudes, which also makes 0x80000000 / -1 fall out as 0x80000000 r 0.
   assign div_s = (op_i == MDU_DIV);
   assign neg_a = div_s & rs_i[31];
   assign neg_b = div_s & rt_i[31];
   assign mag_a = neg_a ? -rs_i : rs_i;
   assign mag_b = neg_b ? -rt_i : rt_i;
   assign den   = (rt_i == 32'd0) ? 32'd1 : mag_b;
   assign q_u   = mag_a / den;
   assign r_u   = mag_a % den;
   assign quo   = (neg_a ^ neg_b) ? -q_u : q_u;
   assign rem   = neg_a ? -r_u : r_u;

   always_comb begin
      res_o = acc;
      case (op_i)
         MDU_MULT:  res_o = prod_s;
         MDU_MULTU: res_o = prod_u;
         MDU_DIV,
         MDU_DIVU: begin
            if (rt_i != 32'd0) res_o = {rem, quo};
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  res_o = acc + prod_s;
         MDU_MADDU: res_o = acc + prod_u;
         MDU_MSUB:  res_o = acc - prod_s;
         MDU_MSUBU: res_o = acc - prod_u;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// MIPS E-stage MDU: owns HI/LO, runs mul/div in MULT_CYCLES/DIV_CYCLES, commits on busy fall.
// Starts while busy are dropped; ops 9-12 (madd/msub family) exist only with MDU_MADD_EN defined.
module e_mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDUOp,
   input  logic        E_start,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   output logic [31:0] E_HILOResult,
   output logic        E_busy,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO
);

   localparam logic [MDU_CNT_W-1:0] MULT_LD = MULT_CYCLES[MDU_CNT_W-1:0];
   localparam logic [MDU_CNT_W-1:0] DIV_LD  = DIV_CYCLES[MDU_CNT_W-1:0];
   localparam logic [MDU_CNT_W-1:0] CNT_ONE = {{(MDU_CNT_W-1){1'b0}}, 1'b1};

   logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]          pend_q, pend_d;
   logic [31:0]          hi_q, hi_d;
   logic [31:0]          lo_q, lo_d;
   logic [63:0]          core_res;
   logic                 busy;
   logic                 long_op;

`ifdef MDU_MADD_EN
   assign long_op = mdu_is_long(E_MDUOp);
`else
   assign long_op = mdu_is_long(E_MDUOp) && (E_MDUOp <= MDU_DIVU);
`endif

   e_mdu_core u_core (
      .op_i  (E_MDUOp),
      .rs_i  (E_rs),
      .rt_i  (E_rt),
      .hi_i  (hi_q),
      .lo_i  (lo_q),
      .res_o (core_res)
   );

   assign busy = (cnt_q != '0);

   always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      if (busy) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
         end
      end else if (E_start) begin
         if (long_op) begin
            cnt_d  = mdu_is_div(E_MDUOp) ? DIV_LD : MULT_LD;
            pend_d = core_res;
         end else if (E_MDUOp == MDU_MTHI) begin
            hi_d = E_rs;
         end else if (E_MDUOp == MDU_MTLO) begin
            lo_d = E_rs;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         pend_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   // No bypass from pending results: reads see architectural HI/LO only.
   always_comb begin
      E_HILOResult = 32'd0;
      if (E_MDUOp == MDU_MFHI)      E_HILOResult = hi_q;
      else if (E_MDUOp == MDU_MFLO) E_HILOResult = lo_q;
   end

   assign E_busy = busy;
   assign E_HI   = hi_q;
   assign E_LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: cycle-stamped reference model plus hand-computed literal checks.
module tb_e_mdu;

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif
   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  E_MDUOp = 4'd0;
   logic        E_start = 1'b0;
   logic [31:0] E_rs = 32'd0;
   logic [31:0] E_rt = 32'd0;
   logic [31:0] E_HILOResult;
   logic        E_busy;
   logic [31:0] E_HI;
   logic [31:0] E_LO;

   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk          (clk),
      .reset        (reset),
      .E_MDUOp      (E_MDUOp),
      .E_start      (E_start),
      .E_rs         (E_rs),
      .E_rt         (E_rt),
      .E_HILOResult (E_HILOResult),
      .E_busy       (E_busy),
      .E_HI         (E_HI),
      .E_LO         (E_LO)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: whole-result arithmetic on 64-bit integers, timing by cycle stamps.
   function automatic logic [63:0] calc(input int op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc, output bit wr);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, uq, ur, res;
      wr  = 1'b1;
      res = acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (op)
         1: res = sa * sb;
         2: res = ua * ub;
         3: if (b == 32'd0) wr = 1'b0;
            else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
         4: if (b == 32'd0) wr = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
         9:  res = acc + sa * sb;
         10: res = acc + ua * ub;
         11: res = acc - sa * sb;
         12: res = acc - ua * ub;
         default: wr = 1'b0;
      endcase
      return res;
   endfunction

   function automatic bit is_long(input int op);
      return (op >= 1 && op <= 4) || (MADD_EN && op >= 9 && op <= 12);
   endfunction

   function automatic bit is_issue(input int op);
      return is_long(op) || op == 7 || op == 8;
   endfunction

   int          cyc = 0;
   int          m_done = 0;
   int          viol = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] m_pend = 64'd0;
   bit          m_wr = 1'b0;
   bit          was_busy;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi   = 32'd0;
         m_lo   = 32'd0;
         m_done = 0;
         m_wr   = 1'b0;
      end else begin
         was_busy = cyc < m_done;
         cyc++;
         if (was_busy) begin
            if (E_start && is_issue(int'(E_MDUOp))) viol++;
            if (cyc == m_done && m_wr) {m_hi, m_lo} = m_pend;
         end else if (E_start) begin
            if (is_long(int'(E_MDUOp))) begin
               m_pend = calc(int'(E_MDUOp), E_rs, E_rt, {m_hi, m_lo}, m_wr);
               m_done = cyc + ((E_MDUOp == 4'd3 || E_MDUOp == 4'd4) ? DIV_N : MULT_N);
            end else if (E_MDUOp == 4'd7) begin
               m_hi = E_rs;
            end else if (E_MDUOp == 4'd8) begin
               m_lo = E_rs;
            end
         end
      end
   end

   logic [31:0] exp_r;
   always @(negedge clk) begin
      if (chk_en && reset) begin
         exp_r = (E_MDUOp == 4'd5) ? m_hi : (E_MDUOp == 4'd6) ? m_lo : 32'd0;
         check("model_busy", 64'(E_busy), 64'(cyc < m_done));
         check("model_hi", 64'(E_HI), 64'(m_hi));
         check("model_lo", 64'(E_LO), 64'(m_lo));
         check("model_hilo_result", 64'(E_HILOResult), 64'(exp_r));
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      E_MDUOp = op; E_rs = a; E_rt = b; E_start = 1'b1;
      @(posedge clk); #1;
      E_start = 1'b0; E_MDUOp = 4'd0;
   endtask

   // Issues op, then counts busy cycles; optionally pulses an illegal MTHI while busy.
   task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int pulse_at, output int cnt);
      bit pulsed = 1'b0;
      issue(op, a, b);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pulsed) begin E_start = 1'b0; E_MDUOp = 4'd0; pulsed = 1'b0; end
         if (!E_busy) break;
         cnt++;
         if (i == pulse_at) begin
            E_MDUOp = 4'd7; E_rs = 32'hDEADBEEF; E_start = 1'b1; pulsed = 1'b1;
         end
      end
   endtask

   task automatic read_reg(input logic [3:0] op, input string name, input logic [31:0] exp);
      @(posedge clk); #1;
      E_MDUOp = op;
      @(negedge clk);
      check(name, 64'(E_HILOResult), 64'(exp));
      @(posedge clk); #1;
      E_MDUOp = 4'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n;
   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_busy", 64'(E_busy), 64'd0);
      check("reset_hi", 64'(E_HI), 64'd0);
      check("reset_lo", 64'(E_LO), 64'd0);
      check("reset_result", 64'(E_HILOResult), 64'd0);

      run_long(4'd1, 32'hFFFFFFFD, 32'd7, -1, n);
      check("mult_busy_cycles", 64'(n), 64'd5);
      check("mult_hi", 64'(E_HI), 64'hFFFFFFFF);
      check("mult_lo", 64'(E_LO), 64'hFFFFFFEB);
      read_reg(4'd5, "mfhi_after_mult", 32'hFFFFFFFF);

      run_long(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, n);
      check("multu_hi", 64'(E_HI), 64'hFFFFFFFE);
      check("multu_lo", 64'(E_LO), 64'h00000001);

      run_long(4'd3, 32'hFFFFFFF9, 32'd2, -1, n);
      check("div_busy_cycles", 64'(n), 64'd10);
      check("div_lo", 64'(E_LO), 64'hFFFFFFFD);
      check("div_hi", 64'(E_HI), 64'hFFFFFFFF);
      read_reg(4'd6, "mflo_after_div", 32'hFFFFFFFD);

      issue(4'd7, 32'h12345678, 32'd0);
      issue(4'd8, 32'h9ABCDEF0, 32'd0);
      check("mthi_hi", 64'(E_HI), 64'h12345678);
      check("mtlo_lo", 64'(E_LO), 64'h9ABCDEF0);
      run_long(4'd4, 32'h55555555, 32'd0, -1, n);
      check("divu0_busy_cycles", 64'(n), 64'd10);
      check("divu0_hi", 64'(E_HI), 64'h12345678);
      check("divu0_lo", 64'(E_LO), 64'h9ABCDEF0);

      run_long(4'd3, 32'h80000000, 32'hFFFFFFFF, 2, n);
      check("divovf_busy_cycles", 64'(n), 64'd10);
      check("divovf_lo", 64'(E_LO), 64'h80000000);
      check("divovf_hi", 64'(E_HI), 64'h00000000);
      check("illegal_issue_seen", 64'(viol), 64'd1);

      issue(4'd7, 32'hA5A5A5A5, 32'd0);
      issue(4'd3, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      check("pre_reset_busy", 64'(E_busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_busy", 64'(E_busy), 64'd0);
      check("async_reset_hi", 64'(E_HI), 64'd0);
      check("async_reset_lo", 64'(E_LO), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (15) @(negedge clk);
      check("post_reset_busy", 64'(E_busy), 64'd0);
      check("post_reset_hi", 64'(E_HI), 64'd0);
      check("post_reset_lo", 64'(E_LO), 64'd0);

      issue(4'd8, 32'hFFFFFFFF, 32'd0);
      run_long(4'd10, 32'd1, 32'd1, -1, n);
      check("maddu_busy_cycles", 64'(n), MADD_EN ? 64'd5 : 64'd0);
      check("maddu_hi", 64'(E_HI), MADD_EN ? 64'h1 : 64'h0);
      check("maddu_lo", 64'(E_LO), MADD_EN ? 64'h0 : 64'hFFFFFFFF);
      run_long(4'd11, 32'd2, 32'd3, -1, n);
      check("msub_hi", 64'(E_HI), 64'h0);
      check("msub_lo", 64'(E_LO), MADD_EN ? 64'hFFFFFFFA : 64'hFFFFFFFF);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
